// File: rtl/alu_disp_pkg.sv
// rtl/alu_disp_pkg.sv - shared input codes, FSM states, slot map and labels for alu_disp_hist
package alu_disp_pkg;

    // input_sel codes as sent by lcd_module
    localparam logic [1:0] SEL_CTRL   = 2'b00;
    localparam logic [1:0] SEL_COMMIT = 2'b01;
    localparam logic [1:0] SEL_SRC1   = 2'b10;
    localparam logic [1:0] SEL_SRC2   = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        CAPT = 2'd2
    } state_t;

    localparam logic [5:0] SLOT_SRC1  = 6'd1;
    localparam logic [5:0] SLOT_SRC2  = 6'd2;
    localparam logic [5:0] SLOT_CONTR = 6'd3;
    localparam logic [5:0] SLOT_RESUL = 6'd4;
    localparam logic [5:0] SLOT_COUNT = 6'd5;
`ifdef ALU_DISP_ZERO_CNT_EN
    localparam logic [5:0] SLOT_ZEROS = 6'd6;
    localparam logic [5:0] SLOT_HIST0 = 6'd7;
`else
    localparam logic [5:0] SLOT_HIST0 = 6'd6;
`endif

    localparam logic [39:0] LBL_SRC1  = "SRC_1";
    localparam logic [39:0] LBL_SRC2  = "SRC_2";
    localparam logic [39:0] LBL_CONTR = "CONTR";
    localparam logic [39:0] LBL_RESUL = "RESUL";
    localparam logic [39:0] LBL_COUNT = "COUNT";
    localparam logic [39:0] LBL_ZEROS = "ZEROS";
    localparam logic [23:0] LBL_HIS   = "HIS";

    // "HISnn" with nn the two-digit decimal age of the entry (0 = newest)
    function automatic logic [39:0] hist_label(input logic [5:0] k);
        logic [5:0] tens;
        logic [5:0] ones;
        tens = k / 6'd10;
        ones = k - tens * 6'd10;
        return {LBL_HIS, 8'h30 + {2'b00, tens}, 8'h30 + {2'b00, ones}};
    endfunction

endpackage

// File: rtl/alu_disp_hist_buf.sv
// rtl/alu_disp_hist_buf.sv - circular result history with newest-relative read port
import alu_disp_pkg::*;

module alu_disp_hist_buf #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [5:0]        rd_idx,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(DEPTH - 1);
    localparam logic [IDX_W-1:0] WRAP  = IDX_W'(DEPTH);
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [IDX_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;

    logic [IDX_W:0]    w_diff;
    logic [IDX_W-1:0]  w_pos;

    // Write newest entry, advance pointer with wrap, saturate the fill count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (wr_en) begin
            r_mem[r_wr_ptr] <= wr_data;
            r_wr_ptr        <= (r_wr_ptr == LAST) ? '0 : r_wr_ptr + IDX_W'(1);
            r_count         <= (r_count == FULL) ? r_count : r_count + CNT_W'(1);
        end
    end

    // Only a valid index (k < count <= DEPTH) matters, so k fits in IDX_W bits
    // and the extra sign bit of w_diff flags underflow; adding DEPTH mod 2^IDX_W
    // then yields (wr_ptr-1-k) mod DEPTH for any DEPTH.
    assign w_diff   = {1'b0, r_wr_ptr} - (IDX_W+1)'(1) - {1'b0, rd_idx[IDX_W-1:0]};
    assign w_pos    = w_diff[IDX_W] ? (w_diff[IDX_W-1:0] + WRAP) : w_diff[IDX_W-1:0];
    assign rd_valid = (8'(rd_idx) < 8'(r_count));
    assign rd_data  = rd_valid ? r_mem[w_pos] : '0;

endmodule

// File: rtl/alu_disp_hist.sv
// rtl/alu_disp_hist.sv - ALU operand capture, timed commit into history, LCD slot mapping (option: ALU_DISP_ZERO_CNT_EN)
import alu_disp_pkg::*;

module alu_disp_hist #(
    parameter int DATA_W     = 32,
    parameter int CTRL_W     = 12,
    parameter int ALU_LAT    = 0,
    parameter int HIST_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        input_sel,
    input  logic              input_valid,
    input  logic [31:0]       input_value,
    input  logic [5:0]        display_number,
    output logic              display_valid,
    output logic [39:0]       display_name,
    output logic [31:0]       display_value,
    output logic [CTRL_W-1:0] alu_control,
    output logic [DATA_W-1:0] alu_src1,
    output logic [DATA_W-1:0] alu_src2,
    input  logic [DATA_W-1:0] alu_result,
    output logic              busy
);

    state_t            r_state;
    logic [3:0]        r_lat_cnt;
    logic              r_busy;
    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_src1;
    logic [DATA_W-1:0] r_src2;
    logic [31:0]       r_commit_cnt;
`ifdef ALU_DISP_ZERO_CNT_EN
    logic [31:0]       r_zero_cnt;
`endif
    logic              r_disp_valid;
    logic [39:0]       r_disp_name;
    logic [31:0]       r_disp_value;

    logic              w_capt;
    logic              w_is_hist;
    logic [5:0]        w_hist_idx;
    logic [DATA_W-1:0] w_hist_data;
    logic              w_hist_valid;
    logic              w_nxt_valid;
    logic [39:0]       w_nxt_name;
    logic [31:0]       w_nxt_value;

    assign w_capt      = (r_state == CAPT);
    assign alu_control = r_ctrl;
    assign alu_src1    = r_src1;
    assign alu_src2    = r_src2;
    assign busy        = r_busy;

    // Operand capture while idle, commit sequencing and counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_lat_cnt    <= '0;
            r_busy       <= 1'b0;
            r_ctrl       <= '0;
            r_src1       <= '0;
            r_src2       <= '0;
            r_commit_cnt <= '0;
`ifdef ALU_DISP_ZERO_CNT_EN
            r_zero_cnt   <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (input_valid) begin
                        case (input_sel)
                            SEL_CTRL: r_ctrl <= input_value[CTRL_W-1:0];
                            SEL_SRC1: r_src1 <= input_value[DATA_W-1:0];
                            SEL_SRC2: r_src2 <= input_value[DATA_W-1:0];
                            default: begin
                                r_busy <= 1'b1;
                                if (ALU_LAT == 0) begin
                                    r_state <= CAPT;
                                end else begin
                                    r_state   <= WAIT;
                                    r_lat_cnt <= 4'(ALU_LAT);
                                end
                            end
                        endcase
                    end
                end
                WAIT: begin
                    r_lat_cnt <= r_lat_cnt - 4'd1;
                    if (r_lat_cnt == 4'd1) begin
                        r_state <= CAPT;
                    end
                end
                CAPT: begin
                    r_commit_cnt <= r_commit_cnt + 32'd1;
`ifdef ALU_DISP_ZERO_CNT_EN
                    if (alu_result == '0) begin
                        r_zero_cnt <= r_zero_cnt + 32'd1;
                    end
`endif
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    alu_disp_hist_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (HIST_DEPTH)
    ) u_hist (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (w_capt),
        .wr_data  (alu_result),
        .rd_idx   (w_hist_idx),
        .rd_data  (w_hist_data),
        .rd_valid (w_hist_valid)
    );

    assign w_hist_idx = display_number - SLOT_HIST0;
    assign w_is_hist  = (display_number >= SLOT_HIST0) &&
                        (7'(display_number) < (7'(SLOT_HIST0) + 7'(HIST_DEPTH)));

    // Slot decode: label and zero-extended value for the slot being drawn
    always_comb begin
        w_nxt_valid = 1'b0;
        w_nxt_name  = '0;
        w_nxt_value = '0;
        case (display_number)
            SLOT_SRC1:  begin w_nxt_valid = 1'b1; w_nxt_name = LBL_SRC1;  w_nxt_value = 32'(r_src1);     end
            SLOT_SRC2:  begin w_nxt_valid = 1'b1; w_nxt_name = LBL_SRC2;  w_nxt_value = 32'(r_src2);     end
            SLOT_CONTR: begin w_nxt_valid = 1'b1; w_nxt_name = LBL_CONTR; w_nxt_value = 32'(r_ctrl);     end
            SLOT_RESUL: begin w_nxt_valid = 1'b1; w_nxt_name = LBL_RESUL; w_nxt_value = 32'(alu_result); end
            SLOT_COUNT: begin w_nxt_valid = 1'b1; w_nxt_name = LBL_COUNT; w_nxt_value = r_commit_cnt;    end
`ifdef ALU_DISP_ZERO_CNT_EN
            SLOT_ZEROS: begin w_nxt_valid = 1'b1; w_nxt_name = LBL_ZEROS; w_nxt_value = r_zero_cnt;      end
`endif
            default: begin
                if (w_is_hist && w_hist_valid) begin
                    w_nxt_valid = 1'b1;
                    w_nxt_name  = hist_label(w_hist_idx);
                    w_nxt_value = 32'(w_hist_data);
                end
            end
        endcase
    end

    // Register display outputs one cycle behind display_number
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_disp_valid <= 1'b0;
            r_disp_name  <= '0;
            r_disp_value <= '0;
        end else begin
            r_disp_valid <= w_nxt_valid;
            r_disp_name  <= w_nxt_name;
            r_disp_value <= w_nxt_value;
        end
    end

    assign display_valid = r_disp_valid;
    assign display_name  = r_disp_name;
    assign display_value = r_disp_value;

endmodule

// File: tb/tb_alu_disp_hist.sv
// tb/tb_alu_disp_hist.sv - scoreboard bench for alu_disp_hist, two instances (latency 0/depth 8, latency 3/depth 5)
module tb_alu_disp_hist;

    localparam int DW = 32;
    localparam int CW = 12;
`ifdef ALU_DISP_ZERO_CNT_EN
    localparam logic [5:0] HIST0 = 6'd7;
`else
    localparam logic [5:0] HIST0 = 6'd6;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    input_sel = 2'b00;
    logic          input_valid = 1'b0;
    logic [31:0]   input_value = 32'd0;
    logic [5:0]    display_number = 6'd0;

    logic          dv_a, dv_b, busy_a, busy_b;
    logic [39:0]   dn_a, dn_b;
    logic [31:0]   dval_a, dval_b;
    logic [CW-1:0] ctrl_a, ctrl_b;
    logic [DW-1:0] s1_a, s2_a, s1_b, s2_b, res_a, res_b;

    // ALU under test modelled as a plain adder
    assign res_a = s1_a + s2_a;
    assign res_b = s1_b + s2_b;

    always #5 clk = ~clk;

    alu_disp_hist #(.DATA_W(DW), .CTRL_W(CW), .ALU_LAT(0), .HIST_DEPTH(8)) dut_a (
        .clk(clk), .reset(reset), .input_sel(input_sel), .input_valid(input_valid),
        .input_value(input_value), .display_number(display_number),
        .display_valid(dv_a), .display_name(dn_a), .display_value(dval_a),
        .alu_control(ctrl_a), .alu_src1(s1_a), .alu_src2(s2_a),
        .alu_result(res_a), .busy(busy_a)
    );

    alu_disp_hist #(.DATA_W(DW), .CTRL_W(CW), .ALU_LAT(3), .HIST_DEPTH(5)) dut_b (
        .clk(clk), .reset(reset), .input_sel(input_sel), .input_valid(input_valid),
        .input_value(input_value), .display_number(display_number),
        .display_valid(dv_b), .display_name(dn_b), .display_value(dval_b),
        .alu_control(ctrl_b), .alu_src1(s1_b), .alu_src2(s2_b),
        .alu_result(res_b), .busy(busy_b)
    );

    typedef struct {
        string       tag;
        logic        v;
        logic [39:0] nm;
        logic [31:0] val;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   n_pass = 0;
    int   n_total = 0;
    logic rd_req = 1'b0;
    logic rd_ack = 1'b0;

    always @(posedge clk) rd_ack <= rd_req;

    function automatic exp_t E(input string tag, input logic v, input logic [39:0] nm, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        e.nm  = nm;
        e.val = val;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h, want %h", tag, got, want);
    endtask

    task automatic chk_disp(input string who, input exp_t e, input logic v, input logic [39:0] nm, input logic [31:0] val);
        n_total++;
        if (v === e.v && nm === e.nm && val === e.val) n_pass++;
        else $display("FAIL %s_%s: got v=%b name=%h val=%h, want v=%b name=%h val=%h",
                      e.tag, who, v, nm, val, e.v, e.nm, e.val);
    endtask

    // Monitor: display outputs present one cycle after a slot request
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rd_ack) begin
                if (q_a.size() == 0 || q_b.size() == 0) begin
                    n_total++;
                    $display("FAIL sb_underflow: got empty queue, want pending entry");
                end else begin
                    e = q_a.pop_front();
                    chk_disp("a", e, dv_a, dn_a, dval_a);
                    e = q_b.pop_front();
                    chk_disp("b", e, dv_b, dn_b, dval_b);
                end
            end
        end
    end

    task automatic wr(input logic [1:0] sel, input logic [31:0] val);
        @(negedge clk);
        input_sel   = sel;
        input_value = val;
        input_valid = 1'b1;
        @(negedge clk);
        input_valid = 1'b0;
    endtask

    task automatic commit(output int na, output int nb);
        na = 0;
        nb = 0;
        @(negedge clk);
        input_sel   = 2'b01;
        input_valid = 1'b1;
        @(negedge clk);
        input_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!busy_a && !busy_b) break;
            if (busy_a) na++;
            if (busy_b) nb++;
            @(negedge clk);
        end
        if (busy_a || busy_b) chk("commit_timeout", 32'({busy_a, busy_b}), 32'd0);
    endtask

    task automatic wait_idle;
        for (int i = 0; i < 20; i++) begin
            if (!busy_a && !busy_b) break;
            @(negedge clk);
        end
        if (busy_a || busy_b) chk("idle_timeout", 32'({busy_a, busy_b}), 32'd0);
    endtask

    task automatic rd(input logic [5:0] slot, input exp_t ea, input exp_t eb);
        @(negedge clk);
        display_number = slot;
        rd_req = 1'b1;
        q_a.push_back(ea);
        q_b.push_back(eb);
        @(negedge clk);
        rd_req = 1'b0;
    endtask

    task automatic rd2(input logic [5:0] slot, input string tag, input logic v, input logic [39:0] nm, input logic [31:0] val);
        rd(slot, E(tag, v, nm, val), E(tag, v, nm, val));
    endtask

    task automatic do_reset;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no finish, want finish before timeout");
        $fatal(1);
    end

    initial begin : stim
        int na, nb;
        repeat (2) @(negedge clk);
        chk("rst_busy_a", 32'(busy_a), 32'd0);
        chk("rst_busy_b", 32'(busy_b), 32'd0);
        chk("rst_dv_a", 32'(dv_a), 32'd0);
        chk("rst_dval_b", dval_b, 32'd0);
        reset = 1'b0;

        rd2(6'd1, "rst_src1", 1'b1, "SRC_1", 32'd0);
        rd2(6'd5, "rst_count", 1'b1, "COUNT", 32'd0);
        rd2(HIST0, "rst_his00", 1'b0, 40'd0, 32'd0);

        // basic commit: 5 + 3, control truncated to 12 bits
        wr(2'b10, 32'h5);
        wr(2'b11, 32'h3);
        wr(2'b00, 32'hABCD_E001);
        commit(na, nb);
        chk("busy_cycles_a", na, 32'd1);
        chk("busy_cycles_b", nb, 32'd4);
        rd2(6'd4, "resul", 1'b1, "RESUL", 32'd8);
        rd2(6'd3, "contr", 1'b1, "CONTR", 32'h001);
        rd2(HIST0, "his00_first", 1'b1, "HIS00", 32'd8);
        rd2(6'd5, "count1", 1'b1, "COUNT", 32'd1);

        // commit, src1 write next cycle (dropped), then a second commit
        @(negedge clk);
        input_sel = 2'b01; input_valid = 1'b1;
        @(negedge clk);
        input_sel = 2'b10; input_value = 32'h99;
        @(negedge clk);
        input_sel = 2'b01;
        @(negedge clk);
        input_valid = 1'b0;
        wait_idle();
        rd2(6'd1, "drop_src1", 1'b1, "SRC_1", 32'd5);
        rd(6'd5, E("busy_commit_cnt", 1'b1, "COUNT", 32'd3), E("busy_commit_cnt", 1'b1, "COUNT", 32'd2));

        // ten commits with results 1..10: wrap and saturation
        do_reset();
        wr(2'b11, 32'd0);
        for (int k = 1; k <= 10; k++) begin
            wr(2'b10, 32'(k));
            commit(na, nb);
        end
        rd2(HIST0, "wrap_his00", 1'b1, "HIS00", 32'd10);
        rd(HIST0 + 6'd7, E("wrap_his07", 1'b1, "HIS07", 32'd3), E("wrap_his07", 1'b0, 40'd0, 32'd0));
        rd2(HIST0 + 6'd4, "wrap_his04", 1'b1, "HIS04", 32'd6);
        rd(HIST0 + 6'd5, E("wrap_his05", 1'b1, "HIS05", 32'd5), E("wrap_his05", 1'b0, 40'd0, 32'd0));
        rd2(HIST0 + 6'd8, "wrap_past_end", 1'b0, 40'd0, 32'd0);
        rd2(6'd5, "wrap_count", 1'b1, "COUNT", 32'd10);

        // partial fill: three entries
        do_reset();
        for (int k = 1; k <= 3; k++) begin
            wr(2'b10, 32'(k));
            commit(na, nb);
        end
        rd2(HIST0 + 6'd2, "part_his02", 1'b1, "HIS02", 32'd1);
        rd2(HIST0 + 6'd3, "part_his03", 1'b0, 40'd0, 32'd0);
        rd2(HIST0 + 6'd7, "part_his07", 1'b0, 40'd0, 32'd0);
        rd2(6'd44, "slot44", 1'b0, 40'd0, 32'd0);
        rd2(6'd0, "slot0", 1'b0, 40'd0, 32'd0);

        // reset asserted mid-commit, between clock edges
        @(negedge clk);
        input_sel = 2'b01; input_valid = 1'b1;
        @(negedge clk);
        input_valid = 1'b0;
        chk("wait_busy_b", 32'(busy_b), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("async_busy_a", 32'(busy_a), 32'd0);
        chk("async_busy_b", 32'(busy_b), 32'd0);
        chk("async_dv_a", 32'(dv_a), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        rd2(6'd5, "post_rst_count", 1'b1, "COUNT", 32'd0);
        rd2(HIST0, "post_rst_his00", 1'b0, 40'd0, 32'd0);

        // results 0, 7, 0
        wr(2'b10, 32'd0);
        commit(na, nb);
        wr(2'b10, 32'd7);
        commit(na, nb);
        wr(2'b10, 32'd0);
        commit(na, nb);
`ifdef ALU_DISP_ZERO_CNT_EN
        rd2(6'd6, "zeros", 1'b1, "ZEROS", 32'd2);
`endif
        rd2(HIST0, "z_his00", 1'b1, "HIS00", 32'd0);
        rd2(HIST0 + 6'd1, "z_his01", 1'b1, "HIS01", 32'd7);
        rd2(6'd5, "z_count", 1'b1, "COUNT", 32'd3);

        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(q_a.size() + q_b.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
